traffic_signal_monitor: RTL and testbench

Consumer end of the controller's NS/EW 3-bit signal-code interface. Debounces the two code buses, decodes them into per-lamp drives, and checks every accepted transition for illegal codes, conflicting greens, bad sequencing and short yellows. On any violation it latches a fault and forces all-way flashing red until an explicit clear. Sits between the signal generator and the lamp output stage.

---
 rtl/traffic_signal_monitor_if.sv | 17 +
 rtl/traffic_signal_monitor.sv | 200 ++++++++++++++++++++
 tb/tb_traffic_signal_monitor.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_signal_monitor_if.sv
// Signal-code interface between the signal generator (master) and the monitor (slave).
// Carries the raw NS/EW codes and fault clear one way, and the lamp drives and fault status the other.
interface traffic_signal_monitor_if;
   logic [2:0] ns_code;
   logic [2:0] ew_code;
   logic       fault_clear;
   logic [2:0] ns_lamp;
   logic [2:0] ew_lamp;
   logic       fault;
   logic [2:0] fault_cause;
   logic       flash;

   modport master (output ns_code, ew_code, fault_clear,
                   input  ns_lamp, ew_lamp, fault, fault_cause, flash);
   modport slave  (input  ns_code, ew_code, fault_clear,
                   output ns_lamp, ew_lamp, fault, fault_cause, flash);
endinterface

// File: rtl/traffic_signal_monitor.sv
// Debounces NS/EW signal codes, drives the lamps, and latches the first rule violation into
// all-way flashing red until cleared. Define WATCHDOG_EN to add the stuck-code timeout (cause 101).
module traffic_signal_monitor #(
   parameter int FILTER      = 2,
   parameter int MIN_YELLOW  = 5,
   parameter int FLASH_HALF  = 10,
   parameter int WDOG_CYCLES = 200
) (
   input  logic                    clk,
   input  logic                    rst,
   traffic_signal_monitor_if.slave bus
);
   localparam int FW = $clog2(FILTER + 1);
   localparam int YW = $clog2(MIN_YELLOW + 1);
   localparam int HW = $clog2(FLASH_HALF + 1);
   localparam logic [2:0] NS_RED   = 3'b011;
   localparam logic [2:0] EW_RED   = 3'b110;
   localparam logic [2:0] LAMP_RED = 3'b100;

   typedef enum logic {RUN, FAULT} state_t;
   typedef enum logic [1:0] {C_BAD, C_GREEN, C_YELLOW, C_RED} color_t;
   typedef enum logic [2:0] {
      CAUSE_NONE         = 3'b000,
      CAUSE_ILLEGAL      = 3'b001,
      CAUSE_CONFLICT     = 3'b010,
      CAUSE_SEQUENCE     = 3'b011,
      CAUSE_SHORT_YELLOW = 3'b100,
      CAUSE_STUCK        = 3'b101
   } cause_t;

   function automatic color_t ns_color(input logic [2:0] code);
      case (code)
         3'b001:  return C_GREEN;
         3'b010:  return C_YELLOW;
         3'b011:  return C_RED;
         default: return C_BAD;
      endcase
   endfunction

   function automatic color_t ew_color(input logic [2:0] code);
      case (code)
         3'b100:  return C_GREEN;
         3'b101:  return C_YELLOW;
         3'b110:  return C_RED;
         default: return C_BAD;
      endcase
   endfunction

   function automatic logic step_ok(input color_t from, input color_t to);
      return (from == C_GREEN  && to == C_YELLOW) ||
             (from == C_YELLOW && to == C_RED)    ||
             (from == C_RED    && to == C_GREEN);
   endfunction

   function automatic logic [2:0] lamp(input color_t c);
      case (c)
         C_GREEN:  return 3'b001;
         C_YELLOW: return 3'b010;
         default:  return LAMP_RED;
      endcase
   endfunction

   state_t          state;
   cause_t          cause_q, cause_nx;
   logic [2:0]      ns_acc, ew_acc, ns_last, ew_last, ns_cand, ew_cand;
   logic [2:0]      ns_lamp_q, ew_lamp_q;
   logic [FW-1:0]   ns_stab, ew_stab, ns_stab_nx, ew_stab_nx;
   logic [YW-1:0]   ns_ycnt, ew_ycnt, ns_yinc, ew_yinc;
   logic [HW-1:0]   flash_cnt;
   logic            flash_q, flash_wrap, ns_evt, ew_evt, clear_ok;
   color_t          ns_from, ns_to, ew_from, ew_to;
`ifdef WATCHDOG_EN
   localparam int WW = $clog2(WDOG_CYCLES + 1);
   logic [WW-1:0]   wdog, wdog_nx;
`endif

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      ns_stab_nx = FW'(1);
      ew_stab_nx = FW'(1);
      if (bus.ns_code == ns_last)
         ns_stab_nx = (ns_stab == FW'(FILTER)) ? ns_stab : ns_stab + FW'(1);
      if (bus.ew_code == ew_last)
         ew_stab_nx = (ew_stab == FW'(FILTER)) ? ew_stab : ew_stab + FW'(1);

      // A code is a candidate only on edges where it is stable and differs from the accepted one.
      ns_evt  = (ns_stab_nx == FW'(FILTER)) && (bus.ns_code != ns_acc);
      ew_evt  = (ew_stab_nx == FW'(FILTER)) && (bus.ew_code != ew_acc);
      ns_cand = ns_evt ? bus.ns_code : ns_acc;
      ew_cand = ew_evt ? bus.ew_code : ew_acc;
      ns_from = ns_color(ns_acc);
      ew_from = ew_color(ew_acc);
      ns_to   = ns_color(ns_cand);
      ew_to   = ew_color(ew_cand);
      ns_yinc = (ns_ycnt == YW'(MIN_YELLOW)) ? ns_ycnt : ns_ycnt + YW'(1);
      ew_yinc = (ew_ycnt == YW'(MIN_YELLOW)) ? ew_ycnt : ew_ycnt + YW'(1);
`ifdef WATCHDOG_EN
      wdog_nx = (ns_evt || ew_evt) ? '0 : wdog + WW'(1);
`endif

      cause_nx = CAUSE_NONE;
      if ((ns_evt && ns_to == C_BAD) || (ew_evt && ew_to == C_BAD))
         cause_nx = CAUSE_ILLEGAL;
      else if ((ns_evt || ew_evt) && ns_to != C_RED && ew_to != C_RED)
         cause_nx = CAUSE_CONFLICT;
      else if ((ns_evt && !step_ok(ns_from, ns_to)) || (ew_evt && !step_ok(ew_from, ew_to)))
         cause_nx = CAUSE_SEQUENCE;
      else if ((ns_evt && ns_from == C_YELLOW && ns_to == C_RED && ns_yinc < YW'(MIN_YELLOW)) ||
               (ew_evt && ew_from == C_YELLOW && ew_to == C_RED && ew_yinc < YW'(MIN_YELLOW)))
         cause_nx = CAUSE_SHORT_YELLOW;
`ifdef WATCHDOG_EN
      else if (wdog_nx == WW'(WDOG_CYCLES))
         cause_nx = CAUSE_STUCK;
`endif

      flash_wrap = (flash_cnt == HW'(FLASH_HALF - 1));
      clear_ok   = bus.fault_clear && bus.ns_code == NS_RED && bus.ew_code == EW_RED;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         cause_q   <= CAUSE_NONE;
         ns_acc    <= NS_RED;
         ew_acc    <= EW_RED;
         ns_last   <= NS_RED;
         ew_last   <= EW_RED;
         ns_stab   <= '0;
         ew_stab   <= '0;
         ns_ycnt   <= '0;
         ew_ycnt   <= '0;
         flash_cnt <= '0;
         flash_q   <= 1'b0;
         ns_lamp_q <= LAMP_RED;
         ew_lamp_q <= LAMP_RED;
`ifdef WATCHDOG_EN
         wdog      <= '0;
`endif
      end else begin
         ns_last <= bus.ns_code;
         ew_last <= bus.ew_code;
         ns_stab <= ns_stab_nx;
         ew_stab <= ew_stab_nx;
         case (state)
            RUN: begin
               if (cause_nx != CAUSE_NONE) begin
                  state     <= FAULT;
                  cause_q   <= cause_nx;
                  flash_q   <= 1'b1;
                  flash_cnt <= '0;
                  ns_lamp_q <= LAMP_RED;
                  ew_lamp_q <= LAMP_RED;
               end else begin
                  if (ns_evt) ns_acc <= bus.ns_code;
                  if (ew_evt) ew_acc <= bus.ew_code;
                  ns_ycnt   <= ns_evt ? '0 : ((ns_from == C_YELLOW) ? ns_yinc : ns_ycnt);
                  ew_ycnt   <= ew_evt ? '0 : ((ew_from == C_YELLOW) ? ew_yinc : ew_ycnt);
                  ns_lamp_q <= lamp(ns_to);
                  ew_lamp_q <= lamp(ew_to);
               end
`ifdef WATCHDOG_EN
               wdog <= (cause_nx != CAUSE_NONE) ? '0 : wdog_nx;
`endif
            end
            FAULT: begin
`ifdef WATCHDOG_EN
               wdog <= '0;
`endif
               if (clear_ok) begin
                  state     <= RUN;
                  cause_q   <= CAUSE_NONE;
                  ns_acc    <= NS_RED;
                  ew_acc    <= EW_RED;
                  // NOTE: the last nonblocking assignment wins, so these override the filter update above.
                  ns_stab   <= '0;
                  ew_stab   <= '0;
                  ns_ycnt   <= '0;
                  ew_ycnt   <= '0;
                  flash_cnt <= '0;
                  flash_q   <= 1'b0;
                  ns_lamp_q <= LAMP_RED;
                  ew_lamp_q <= LAMP_RED;
               end else begin
                  flash_cnt <= flash_wrap ? '0 : flash_cnt + HW'(1);
                  flash_q   <= flash_q ^ flash_wrap;
                  ns_lamp_q <= {flash_q ^ flash_wrap, 2'b00};
                  ew_lamp_q <= {flash_q ^ flash_wrap, 2'b00};
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   assign bus.ns_lamp     = ns_lamp_q;
   assign bus.ew_lamp     = ew_lamp_q;
   assign bus.fault       = (state == FAULT);
   assign bus.fault_cause = cause_q;
   assign bus.flash       = flash_q;
endmodule

// File: tb/tb_traffic_signal_monitor.sv
// Directed bench for traffic_signal_monitor: filtering, lamp decode, each fault cause,
// flashing, fault clear and asynchronous reset, with hand-computed expected outputs.
module tb_traffic_signal_monitor;
   localparam logic [2:0] NG = 3'b001, NY = 3'b010, NR = 3'b011;
   localparam logic [2:0] EG = 3'b100, EY = 3'b101, ER = 3'b110;
   localparam logic [2:0] LG = 3'b001, LY = 3'b010, LR = 3'b100, LO = 3'b000;

   logic clk = 1'b0;
   logic rst;
   int   vectors = 0;
   int   miscompares = 0;
   logic [10:0] want;

   traffic_signal_monitor_if bus ();

   traffic_signal_monitor #(
      .FILTER(2), .MIN_YELLOW(5), .FLASH_HALF(10), .WDOG_CYCLES(200)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // {ns_lamp, ew_lamp, fault, fault_cause, flash}
   function automatic logic [10:0] obs();
      return {bus.ns_lamp, bus.ew_lamp, bus.fault, bus.fault_cause, bus.flash};
   endfunction

   function automatic logic [10:0] pack(input logic [2:0] n, input logic [2:0] e,
                                        input logic f, input logic [2:0] c, input logic fl);
      return {n, e, f, c, fl};
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] ns, input logic [2:0] ew);
      bus.ns_code = ns;
      bus.ew_code = ew;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.fault_clear = 1'b0;
      drive(NR, ER);
      step(2);
      rst = 1'b0;
   endtask

   task automatic clear_fault();
      drive(NR, ER);
      bus.fault_clear = 1'b1;
      step(1);
      bus.fault_clear = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 50; i++) begin
         want = pack(LR, LR, 1'b0, 3'b000, 1'b0);
         vectors++;
         if (obs() !== want) begin
            miscompares++;
            $display("FAIL reset_hold cycle %0d: got %b want %b", i, obs(), want);
         end
         step(1);
      end
   endtask

   task automatic test_normal_cycle();
      drive(NG, ER);
      step(1);
      want = pack(LR, LR, 1'b0, 3'b000, 1'b0); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL ns_green_early: got %b want %b", obs(), want); end
      step(1);
      want = pack(LG, LR, 1'b0, 3'b000, 1'b0); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL ns_green_latency: got %b want %b", obs(), want); end
      drive(NY, ER);
      step(2);
      want = pack(LY, LR, 1'b0, 3'b000, 1'b0); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL ns_yellow: got %b want %b", obs(), want); end
      step(3);
      drive(NR, ER);
      step(1);
      want = pack(LY, LR, 1'b0, 3'b000, 1'b0); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL ns_red_early: got %b want %b", obs(), want); end
      step(1);
      want = pack(LR, LR, 1'b0, 3'b000, 1'b0); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL ns_yellow_min_legal: got %b want %b", obs(), want); end
      drive(NR, EG);
      step(2);
      want = pack(LR, LG, 1'b0, 3'b000, 1'b0); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL ew_green: got %b want %b", obs(), want); end
      drive(NR, EY);
      step(5);
      drive(NR, ER);
      step(2);
      want = pack(LR, LR, 1'b0, 3'b000, 1'b0); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL ew_cycle_done: got %b want %b", obs(), want); end
   endtask

   task automatic test_back_to_back();
      drive(NG, ER); step(2);
      drive(NY, ER); step(5);
      drive(NR, EG); step(2);
      want = pack(LR, LG, 1'b0, 3'b000, 1'b0); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL simultaneous_handover: got %b want %b", obs(), want); end
      drive(NR, EY); step(5);
      drive(NR, ER); step(2);
      want = pack(LR, LR, 1'b0, 3'b000, 1'b0); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL handover_back_red: got %b want %b", obs(), want); end
   endtask

   task automatic test_glitch();
      drive(NG, ER); step(2);
      drive(NY, ER); step(2);
      drive(3'b111, ER); step(1);
      drive(NY, ER); step(3);
      want = pack(LY, LR, 1'b0, 3'b000, 1'b0); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL glitch_ignored: got %b want %b", obs(), want); end
      drive(NR, ER); step(2);
      want = pack(LR, LR, 1'b0, 3'b000, 1'b0); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL glitch_then_red: got %b want %b", obs(), want); end
   endtask

   task automatic test_conflict_flash();
      drive(NG, ER); step(2);
      drive(NG, EG); step(1);
      want = pack(LG, LR, 1'b0, 3'b000, 1'b0); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL conflict_early: got %b want %b", obs(), want); end
      step(1);
      want = pack(LR, LR, 1'b1, 3'b010, 1'b1); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL conflict_entry: got %b want %b", obs(), want); end
      drive(3'b111, EG);
      step(9);
      want = pack(LR, LR, 1'b1, 3'b010, 1'b1); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL flash_before_toggle: got %b want %b", obs(), want); end
      step(1);
      want = pack(LO, LO, 1'b1, 3'b010, 1'b0); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL flash_off: got %b want %b", obs(), want); end
      step(9);
      want = pack(LO, LO, 1'b1, 3'b010, 1'b0); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL flash_off_hold: got %b want %b", obs(), want); end
      step(1);
      want = pack(LR, LR, 1'b1, 3'b010, 1'b1); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL flash_on_again: got %b want %b", obs(), want); end
   endtask

   task automatic test_fault_clear();
      bus.fault_clear = 1'b1;
      drive(NG, ER);
      step(1);
      vectors++;
      if ({bus.fault, bus.fault_cause} !== 4'b1010) begin
         miscompares++;
         $display("FAIL clear_rejected: got %b want %b", {bus.fault, bus.fault_cause}, 4'b1010);
      end
      drive(NR, ER);
      step(1);
      bus.fault_clear = 1'b0;
      want = pack(LR, LR, 1'b0, 3'b000, 1'b0); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL clear_accepted: got %b want %b", obs(), want); end
      drive(NG, ER); step(2);
      want = pack(LG, LR, 1'b0, 3'b000, 1'b0); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL run_after_clear: got %b want %b", obs(), want); end
      drive(NY, ER); step(5);
      drive(NR, ER); step(2);
   endtask

   task automatic test_short_yellow();
      drive(NG, ER); step(2);
      drive(NY, ER);
      bus.fault_clear = 1'b1;
      step(4);
      drive(NR, ER);
      step(1);
      want = pack(LY, LR, 1'b0, 3'b000, 1'b0); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL short_yellow_early: got %b want %b", obs(), want); end
      step(1);
      want = pack(LR, LR, 1'b1, 3'b100, 1'b1); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL short_yellow: got %b want %b", obs(), want); end
      step(1);
      bus.fault_clear = 1'b0;
      want = pack(LR, LR, 1'b0, 3'b000, 1'b0); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL short_yellow_cleared: got %b want %b", obs(), want); end
   endtask

   task automatic test_illegal();
      drive(NG, ER); step(2);
      drive(NG, 3'b111); step(2);
      want = pack(LR, LR, 1'b1, 3'b001, 1'b1); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL illegal_over_conflict: got %b want %b", obs(), want); end
      clear_fault();
      drive(3'b000, ER); step(2);
      want = pack(LR, LR, 1'b1, 3'b001, 1'b1); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL illegal_ns: got %b want %b", obs(), want); end
      clear_fault();
      want = pack(LR, LR, 1'b0, 3'b000, 1'b0); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL illegal_cleared: got %b want %b", obs(), want); end
   endtask

   task automatic test_sequence();
      drive(NY, ER); step(2);
      want = pack(LR, LR, 1'b1, 3'b011, 1'b1); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL seq_red_to_yellow: got %b want %b", obs(), want); end
      clear_fault();
      drive(NR, EG); step(2);
      want = pack(LR, LG, 1'b0, 3'b000, 1'b0); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL seq_ew_green: got %b want %b", obs(), want); end
      drive(NR, ER); step(2);
      want = pack(LR, LR, 1'b1, 3'b011, 1'b1); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL seq_green_to_red: got %b want %b", obs(), want); end
      clear_fault();
   endtask

   task automatic test_reset_in_fault();
      drive(NY, ER); step(2);
      want = pack(LR, LR, 1'b1, 3'b011, 1'b1); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL pre_reset_fault: got %b want %b", obs(), want); end
      #2 rst = 1'b1;
      #1;
      want = pack(LR, LR, 1'b0, 3'b000, 1'b0); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL async_reset: got %b want %b", obs(), want); end
      drive(NR, ER);
      step(2);
      rst = 1'b0;
      step(3);
      want = pack(LR, LR, 1'b0, 3'b000, 1'b0); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL after_reset_release: got %b want %b", obs(), want); end
   endtask

`ifdef WATCHDOG_EN
   task automatic test_watchdog();
      do_reset();
      step(199);
      want = pack(LR, LR, 1'b0, 3'b000, 1'b0); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL wdog_before: got %b want %b", obs(), want); end
      step(1);
      want = pack(LR, LR, 1'b1, 3'b101, 1'b1); vectors++;
      if (obs() !== want) begin miscompares++; $display("FAIL wdog_trip: got %b want %b", obs(), want); end
      do_reset();
   endtask
`endif

   initial begin
      rst = 1'b1;
      bus.fault_clear = 1'b0;
      drive(NR, ER);
      test_reset();
      test_normal_cycle();
      test_back_to_back();
      test_glitch();
      test_conflict_flash();
      test_fault_clear();
      test_short_yellow();
      test_illegal();
      test_sequence();
      test_reset_in_fault();
`ifdef WATCHDOG_EN
      test_watchdog();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
